serial_msg_transmitter: RTL and testbench
=========================================

# serial_msg_transmitter

Frames outbound particle-filter results for the UART link to the host. On request it emits a fixed ASCII start header chosen by message type, then a fixed number of payload bytes pulled from the result producer, optionally followed by a checksum byte. It sits between the result/pose logic and the UART byte transmitter, and is the transmit-side counterpart of the header-detecting message receiver.

## Interface
Parameters:
- POSE_HEADER, "KLMNO": start header for pose messages; first character sent first.
- POSE_HEADER_LENGTH_BYTE, 5: pose header length in bytes (≥1).
- STATUS_HEADER, "PQRST": start header for status messages.
- STATUS_HEADER_LENGTH_BYTE, 5: status header length in bytes (≥1).
- POSE_MESSAGE_LENGTH, 12: pose payload bytes (≥1).
- STATUS_MESSAGE_LENGTH, 4: status payload bytes (≥1).

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- send_req  in  1  request to start a message; sampled only in IDLE.
- send_type  in  1  0 = pose, 1 = status; sampled with send_req.
- busy  out  1  high from acceptance until return to IDLE.
- in_data  in  8  payload byte from producer.
- in_valid  in  1  in_data valid.
- in_ready  out  1  payload byte consumed this cycle when in_valid is also high.
- tx_data  out  8  byte to UART transmitter (registered).
- tx_valid  out  1  tx_data valid (registered).
- tx_ready  in  1  UART accepts tx_data this cycle.
- msg_done  out  1  one-cycle pulse after last byte of a message is accepted.

## Operation
- States: IDLE, HEADER, PAYLOAD, CHECKSUM (only with macro).
- IDLE: send_req=1 latches send_type, loads header length/payload length, goes to HEADER with tx_data = header byte 0, tx_valid=1, busy=1.
- HEADER: on each tx_valid&&tx_ready, advance byte index. After the last header byte is accepted, go to PAYLOAD.
- PAYLOAD: in_ready = state==PAYLOAD && remaining>0 && (!tx_valid || tx_ready). A byte transferred on in_valid&&in_ready loads tx_data and decrements remaining. After the last payload byte is accepted on tx, go to CHECKSUM or IDLE.
- Header byte k is taken MSB-first: bits [8*LEN-1-8k -: 8] of the header parameter.
- Counter widths are the minimum bits for the larger header length and the larger payload length. Remaining-count underflow must never occur.
- send_req outside IDLE is ignored. There is no queuing.
- in_valid low in PAYLOAD produces a tx bubble: tx_valid drops after the current byte is accepted. There is no timeout.
- While tx_valid=1 and tx_ready=0, tx_data and tx_valid hold stable.
- Reset mid-message aborts the message. The receiving end resynchronises on the next header.

## Timing
- Reset values: tx_data=0, tx_valid=0, busy=0, msg_done=0. in_ready=0 (derived).
- tx_valid rises with header byte 0 in the cycle after send_req is sampled.
- The next byte is presented in the cycle after the previous byte is accepted. There are no bubbles when tx_ready and in_valid stay high.
- Minimum message duration is H+N(+1) cycles of tx_valid for header length H and payload length N, plus 1 for the checksum.
- msg_done and busy=0 occur in the cycle after the final accept. IDLE can accept send_req in that same cycle, so the minimum gap between messages is 1 cycle.

## Configuration
- SERIAL_MSG_TX_CHECKSUM_EN defined: after the payload, emit one byte equal to the sum mod 256 of all payload bytes (header excluded). The running sum clears in IDLE. msg_done follows the checksum accept.
- SERIAL_MSG_TX_CHECKSUM_EN undefined: there is no CHECKSUM state and no accumulator. msg_done follows the last payload accept.

## Structure
- Shared package serial_msg_pkg holds:
  - state encoding;
  - message-type constants: MSG_TYPE_POSE=0, MSG_TYPE_STATUS=1;
  - the MinBitWidth width function.
- Sub-module serial_msg_header_rom: combinational; takes type and byte index, returns header byte and last-byte flag.

## Test plan
- Pose request, tx_ready=1, in_valid=1 with payload 0x01..0x0C: tx stream "KLMNO" then 0x01..0x0C.
  - msg_done one cycle after the 17th accept.
  - With the macro, 18th byte = 0x4E.
- Status request, tx_ready toggling 1/0 each cycle: "PQRST" plus 4 bytes, each tx_data stable while tx_ready=0. busy stays high throughout.
- in_valid low for 3 cycles mid-payload: tx_valid=0 gap appears, byte order is preserved, and no bytes are lost or duplicated.
- send_req pulsed during HEADER with send_type=1: ignored, and the current pose message completes unchanged.
- Reset asserted mid-payload: tx_valid, busy and msg_done go to 0 immediately. A following pose request restarts from 'K'.
- send_req held high continuously: back-to-back messages with exactly one idle cycle between final accept and the next header byte 0.

Source files
------------

// File: rtl/serial_msg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_msg_pkg
//  Purpose  : Shared types and helpers for the serial message transmitter.
//             The CHECKSUM state exists only when SERIAL_MSG_TX_CHECKSUM_EN
//             is defined.
//  Revision : 1.0 - initial release
// ============================================================================
package serial_msg_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HEADER   = 2'd1,
      PAYLOAD  = 2'd2
`ifdef SERIAL_MSG_TX_CHECKSUM_EN
      ,
      CHECKSUM = 2'd3
`endif
   } state_t;

   localparam logic MSG_TYPE_POSE   = 1'b0;
   localparam logic MSG_TYPE_STATUS = 1'b1;

   // Number of bits needed to hold the non-negative value (at least 1).
   function automatic int MinBitWidth(input int value);
      for (int w = 1; w < 32; w++) begin
         if ((value >> w) == 0) return w;
      end
      return 32;
   endfunction

endpackage
`default_nettype wire

// File: rtl/serial_msg_transmitter_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_msg_transmitter_if
//  Purpose  : Request, payload and UART-side handshake bundle of the
//             serial message transmitter. master = transmitter side,
//             slave = surrounding logic.
//  Revision : 1.0 - initial release
// ============================================================================
interface serial_msg_transmitter_if;
   logic       send_req;
   logic       send_type;
   logic       busy;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       msg_done;

   modport master (
      input  send_req, send_type, in_data, in_valid, tx_ready,
      output busy, in_ready, tx_data, tx_valid, msg_done
   );

   modport slave (
      output send_req, send_type, in_data, in_valid, tx_ready,
      input  busy, in_ready, tx_data, tx_valid, msg_done
   );
endinterface
`default_nettype wire

// File: rtl/serial_msg_header_rom.sv
`default_nettype none
// ============================================================================
//  Module   : serial_msg_header_rom
//  Purpose  : Combinational lookup of start-header byte k (first character
//             first) for the selected message type, plus last-byte flag.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_msg_header_rom
   import serial_msg_pkg::*;
#(
   parameter int                                   POSE_HEADER_LENGTH_BYTE   = 5,
   parameter logic [8*POSE_HEADER_LENGTH_BYTE-1:0]   POSE_HEADER   = "KLMNO",
   parameter int                                   STATUS_HEADER_LENGTH_BYTE = 5,
   parameter logic [8*STATUS_HEADER_LENGTH_BYTE-1:0] STATUS_HEADER = "PQRST",
   parameter int                                   IDX_WIDTH                 = 3
)(
   input  logic                 msg_type,
   input  logic [IDX_WIDTH-1:0] byte_idx,
   output logic [7:0]           hdr_byte,
   output logic                 last_byte
);

   logic [8*POSE_HEADER_LENGTH_BYTE-1:0]   pose_shifted;
   logic [8*STATUS_HEADER_LENGTH_BYTE-1:0] status_shifted;
   int                                     idx_int;

   // Shift the wanted character down to the low byte; out-of-range indices yield 0.
   always_comb begin
      idx_int        = int'(byte_idx);
      pose_shifted   = '0;
      status_shifted = '0;
      if (idx_int < POSE_HEADER_LENGTH_BYTE)
         pose_shifted = POSE_HEADER >> (8 * (POSE_HEADER_LENGTH_BYTE - 1 - idx_int));
      if (idx_int < STATUS_HEADER_LENGTH_BYTE)
         status_shifted = STATUS_HEADER >> (8 * (STATUS_HEADER_LENGTH_BYTE - 1 - idx_int));
      if (msg_type == MSG_TYPE_STATUS) begin
         hdr_byte  = status_shifted[7:0];
         last_byte = (idx_int >= STATUS_HEADER_LENGTH_BYTE - 1);
      end else begin
         hdr_byte  = pose_shifted[7:0];
         last_byte = (idx_int >= POSE_HEADER_LENGTH_BYTE - 1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/serial_msg_transmitter.sv
`default_nettype none
// ============================================================================
//  Module   : serial_msg_transmitter
//  Purpose  : Frames outbound messages for the UART: type-selected ASCII
//             header, fixed-length payload pulled from a producer, and an
//             optional sum-mod-256 checksum byte (SERIAL_MSG_TX_CHECKSUM_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module serial_msg_transmitter
   import serial_msg_pkg::*;
#(
   parameter int                                   POSE_HEADER_LENGTH_BYTE   = 5,
   parameter logic [8*POSE_HEADER_LENGTH_BYTE-1:0]   POSE_HEADER   = "KLMNO",
   parameter int                                   STATUS_HEADER_LENGTH_BYTE = 5,
   parameter logic [8*STATUS_HEADER_LENGTH_BYTE-1:0] STATUS_HEADER = "PQRST",
   parameter int                                   POSE_MESSAGE_LENGTH       = 12,
   parameter int                                   STATUS_MESSAGE_LENGTH     = 4
)(
   input  logic                      clk,
   input  logic                      reset,
   serial_msg_transmitter_if.master  bus
);

   localparam int HDR_MAX = (POSE_HEADER_LENGTH_BYTE > STATUS_HEADER_LENGTH_BYTE) ?
                            POSE_HEADER_LENGTH_BYTE : STATUS_HEADER_LENGTH_BYTE;
   localparam int PAY_MAX = (POSE_MESSAGE_LENGTH > STATUS_MESSAGE_LENGTH) ?
                            POSE_MESSAGE_LENGTH : STATUS_MESSAGE_LENGTH;
   localparam int IDX_W   = MinBitWidth(HDR_MAX);
   localparam int REM_W   = MinBitWidth(PAY_MAX);

   state_t             state, state_next;
   logic               msg_type, msg_type_next;
   logic [IDX_W-1:0]   hdr_idx, hdr_idx_next;
   logic [REM_W-1:0]   remaining, remaining_next;
   logic [7:0]         tx_data_q, tx_data_next;
   logic               tx_valid_q, tx_valid_next;
   logic               msg_done_q, msg_done_next;
`ifdef SERIAL_MSG_TX_CHECKSUM_EN
   logic [7:0]         sum, sum_next;
`endif

   logic               rom_type;
   logic [IDX_W-1:0]   rom_idx;
   logic [7:0]         rom_byte;
   logic               rom_last;
   logic               tx_accept;
   logic               pay_xfer;
   logic               in_ready_int;

   // In IDLE the ROM looks at the incoming request so header byte 0 can be
   // registered in the acceptance cycle; afterwards it follows the latched type.
   assign rom_type = (state == IDLE) ? bus.send_type : msg_type;
   assign rom_idx  = (state == IDLE) ? '0 : hdr_idx;

   serial_msg_header_rom #(
      .POSE_HEADER_LENGTH_BYTE   (POSE_HEADER_LENGTH_BYTE),
      .POSE_HEADER               (POSE_HEADER),
      .STATUS_HEADER_LENGTH_BYTE (STATUS_HEADER_LENGTH_BYTE),
      .STATUS_HEADER             (STATUS_HEADER),
      .IDX_WIDTH                 (IDX_W)
   ) u_header_rom (
      .msg_type  (rom_type),
      .byte_idx  (rom_idx),
      .hdr_byte  (rom_byte),
      .last_byte (rom_last)
   );

   // Next-state and datapath decode. PAYLOAD is entered as soon as the last
   // header byte is on tx, so the first payload byte loads on its accept
   // and the stream has no bubble at the header/payload seam.
   always_comb begin
      state_next     = state;
      msg_type_next  = msg_type;
      hdr_idx_next   = hdr_idx;
      remaining_next = remaining;
      tx_data_next   = tx_data_q;
      tx_valid_next  = tx_valid_q;
      msg_done_next  = 1'b0;
`ifdef SERIAL_MSG_TX_CHECKSUM_EN
      sum_next       = sum;
`endif
      tx_accept    = tx_valid_q && bus.tx_ready;
      in_ready_int = (state == PAYLOAD) && (remaining != '0) && (!tx_valid_q || bus.tx_ready);
      pay_xfer     = in_ready_int && bus.in_valid;

      case (state)
         IDLE: begin
`ifdef SERIAL_MSG_TX_CHECKSUM_EN
            sum_next = '0;
`endif
            if (bus.send_req) begin
               msg_type_next  = bus.send_type;
               remaining_next = (bus.send_type == MSG_TYPE_POSE) ?
                                REM_W'(POSE_MESSAGE_LENGTH) : REM_W'(STATUS_MESSAGE_LENGTH);
               tx_data_next   = rom_byte;
               tx_valid_next  = 1'b1;
               hdr_idx_next   = IDX_W'(1);
               state_next     = rom_last ? PAYLOAD : HEADER;
            end
         end

         HEADER: begin
            if (tx_accept) begin
               tx_data_next = rom_byte;
               hdr_idx_next = hdr_idx + IDX_W'(1);
               if (rom_last) state_next = PAYLOAD;
            end
         end

         PAYLOAD: begin
            if (pay_xfer) begin
               tx_data_next   = bus.in_data;
               tx_valid_next  = 1'b1;
               remaining_next = remaining - REM_W'(1);
`ifdef SERIAL_MSG_TX_CHECKSUM_EN
               sum_next       = sum + bus.in_data;
`endif
            end else if (tx_accept) begin
               tx_valid_next = 1'b0;
               if (remaining == '0) begin
`ifdef SERIAL_MSG_TX_CHECKSUM_EN
                  tx_data_next  = sum;
                  tx_valid_next = 1'b1;
                  state_next    = CHECKSUM;
`else
                  msg_done_next = 1'b1;
                  state_next    = IDLE;
`endif
               end
            end
         end

`ifdef SERIAL_MSG_TX_CHECKSUM_EN
         CHECKSUM: begin
            if (tx_accept) begin
               tx_valid_next = 1'b0;
               msg_done_next = 1'b1;
               state_next    = IDLE;
            end
         end
`endif

         default: begin
            tx_valid_next = 1'b0;
            state_next    = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any message in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         msg_type   <= MSG_TYPE_POSE;
         hdr_idx    <= '0;
         remaining  <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         msg_done_q <= 1'b0;
`ifdef SERIAL_MSG_TX_CHECKSUM_EN
         sum        <= '0;
`endif
      end else begin
         state      <= state_next;
         msg_type   <= msg_type_next;
         hdr_idx    <= hdr_idx_next;
         remaining  <= remaining_next;
         tx_data_q  <= tx_data_next;
         tx_valid_q <= tx_valid_next;
         msg_done_q <= msg_done_next;
`ifdef SERIAL_MSG_TX_CHECKSUM_EN
         sum        <= sum_next;
`endif
      end
   end

   assign bus.tx_data  = tx_data_q;
   assign bus.tx_valid = tx_valid_q;
   assign bus.msg_done = msg_done_q;
   assign bus.busy     = (state != IDLE);
   assign bus.in_ready = in_ready_int;

endmodule
`default_nettype wire

// File: tb/tb_serial_msg_transmitter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_msg_transmitter
//  Purpose  : Self-checking bench for serial_msg_transmitter: table of
//             message scenarios plus reset and back-to-back sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_msg_transmitter;
   import serial_msg_pkg::*;

`ifdef SERIAL_MSG_TX_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif
   localparam int HLEN = 5;

   logic clk = 1'b0;
   logic reset;

   serial_msg_transmitter_if bus_if();

   serial_msg_transmitter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        typ;
      logic        toggle;
      int          gap_after;
      int          poke_at;
      logic [7:0]  base;
      logic [39:0] exp_hdr;
      int          exp_n;
      logic [7:0]  exp_csum;
      logic        exp_bubble;
   } vec_t;

   vec_t       vecs [5];
   int         passed = 0;
   int         total  = 0;
   logic [7:0] pq [$];
   logic [7:0] acc_q [$];
   int         acc_cyc [$];
   int         cyc = 0, gap = 0, done_cnt = 0, done_cyc = -1;
   int         bubble_cnt = 0, busy_low_cnt = 0;
   logic       toggle_mode = 1'b0, prev_stall = 1'b0, busy_at_done = 1'b0;
   logic [7:0] prev_data = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      else passed++;
   endtask

   // One clock: drive producer/UART inputs after the edge, sample at negedge.
   task automatic tick();
      @(posedge clk);
      #2;
      bus_if.tx_ready = toggle_mode ? ~bus_if.tx_ready : 1'b1;
      if (gap > 0) begin
         bus_if.in_valid = 1'b0;
         gap--;
      end else if (pq.size() > 0) begin
         bus_if.in_valid = 1'b1;
         bus_if.in_data  = pq[0];
      end else begin
         bus_if.in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (prev_stall)
         chk("hold_stable", {23'd0, bus_if.tx_valid, bus_if.tx_data}, {23'd0, 1'b1, prev_data});
      prev_stall = bus_if.tx_valid && !bus_if.tx_ready;
      prev_data  = bus_if.tx_data;
      if (bus_if.busy && !bus_if.tx_valid) bubble_cnt++;
      if (!bus_if.busy) busy_low_cnt++;
      if (bus_if.tx_valid && bus_if.tx_ready) begin
         acc_q.push_back(bus_if.tx_data);
         acc_cyc.push_back(cyc);
      end
      if (bus_if.msg_done) begin
         done_cnt++;
         done_cyc     = cyc;
         busy_at_done = bus_if.busy;
      end
      if (bus_if.in_valid && bus_if.in_ready) void'(pq.pop_front());
   endtask

   task automatic clear_obs();
      acc_q.delete();
      acc_cyc.delete();
      done_cnt     = 0;
      done_cyc     = -1;
      bubble_cnt   = 0;
      busy_low_cnt = 0;
   endtask

   task automatic run_vec(input vec_t v, input int vi);
      logic [39:0] h;
      logic [7:0]  e;
      int          budget;
      int          len;
      logic        gap_done;
      pq.delete();
      for (int i = 0; i < v.exp_n; i++) pq.push_back(v.base + 8'(i));
      clear_obs();
      toggle_mode      = v.toggle;
      bus_if.send_type = v.typ;
      bus_if.send_req  = 1'b1;
      tick();
      bus_if.send_req  = 1'b0;
      budget   = 0;
      gap_done = 1'b0;
      while (done_cnt == 0 && budget < 300) begin
         if (v.poke_at > 0 && budget == v.poke_at) begin
            bus_if.send_req  = 1'b1;
            bus_if.send_type = MSG_TYPE_STATUS;
         end else begin
            bus_if.send_req  = 1'b0;
         end
         if (v.gap_after > 0 && !gap_done && acc_q.size() >= v.gap_after) begin
            gap      = 3;
            gap_done = 1'b1;
         end
         tick();
         budget++;
      end
      bus_if.send_req = 1'b0;
      len = HLEN + v.exp_n + CS;
      chk($sformatf("v%0d_done_count", vi), done_cnt, 1);
      chk($sformatf("v%0d_stream_len", vi), acc_q.size(), len);
      chk($sformatf("v%0d_producer_drained", vi), pq.size(), 0);
      if (acc_q.size() == len) begin
         h = v.exp_hdr;
         for (int k = 0; k < HLEN; k++)
            chk($sformatf("v%0d_hdr%0d", vi, k), acc_q[k], h[39-8*k -: 8]);
         for (int i = 0; i < v.exp_n; i++) begin
            e = v.base + 8'(i);
            chk($sformatf("v%0d_pay%0d", vi, i), acc_q[HLEN+i], e);
         end
`ifdef SERIAL_MSG_TX_CHECKSUM_EN
         chk($sformatf("v%0d_checksum", vi), acc_q[len-1], v.exp_csum);
`endif
         chk($sformatf("v%0d_done_timing", vi), done_cyc, acc_cyc[len-1] + 1);
         if (!v.toggle && !v.exp_bubble)
            chk($sformatf("v%0d_no_bubble_span", vi), acc_cyc[len-1] - acc_cyc[0], len - 1);
      end
      chk($sformatf("v%0d_busy_at_done", vi), busy_at_done, 1'b0);
      chk($sformatf("v%0d_busy_low_cycles", vi), busy_low_cnt, 1);
      chk($sformatf("v%0d_bubble_seen", vi), bubble_cnt != 0, v.exp_bubble);
   endtask

   initial begin
      int budget;
      int n1;
      int first_done;

      vecs[0] = '{typ:1'b0, toggle:1'b0, gap_after:0, poke_at:0, base:8'h01,
                  exp_hdr:"KLMNO", exp_n:12, exp_csum:8'h4E, exp_bubble:1'b0};
      vecs[1] = '{typ:1'b1, toggle:1'b1, gap_after:0, poke_at:0, base:8'hF0,
                  exp_hdr:"PQRST", exp_n:4,  exp_csum:8'hC6, exp_bubble:1'b0};
      vecs[2] = '{typ:1'b0, toggle:1'b0, gap_after:8, poke_at:0, base:8'h20,
                  exp_hdr:"KLMNO", exp_n:12, exp_csum:8'hC2, exp_bubble:1'b1};
      vecs[3] = '{typ:1'b0, toggle:1'b1, gap_after:0, poke_at:0, base:8'h80,
                  exp_hdr:"KLMNO", exp_n:12, exp_csum:8'h42, exp_bubble:1'b0};
      vecs[4] = '{typ:1'b0, toggle:1'b0, gap_after:0, poke_at:2, base:8'h30,
                  exp_hdr:"KLMNO", exp_n:12, exp_csum:8'h82, exp_bubble:1'b0};

      reset            = 1'b0;
      bus_if.send_req  = 1'b0;
      bus_if.send_type = 1'b0;
      bus_if.in_data   = 8'h00;
      bus_if.in_valid  = 1'b0;
      bus_if.tx_ready  = 1'b0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("reset_tx_data",  bus_if.tx_data,  8'h00);
      chk("reset_tx_valid", bus_if.tx_valid, 1'b0);
      chk("reset_busy",     bus_if.busy,     1'b0);
      chk("reset_msg_done", bus_if.msg_done, 1'b0);
      chk("reset_in_ready", bus_if.in_ready, 1'b0);
      reset = 1'b1;
      tick();

      for (int vi = 0; vi < 5; vi++) begin
         run_vec(vecs[vi], vi);
         tick();
      end

      // Reset asserted mid-payload, then a fresh pose message
      pq.delete();
      for (int i = 0; i < 12; i++) pq.push_back(8'h01 + 8'(i));
      clear_obs();
      toggle_mode      = 1'b0;
      bus_if.send_type = MSG_TYPE_POSE;
      bus_if.send_req  = 1'b1;
      tick();
      bus_if.send_req  = 1'b0;
      budget = 0;
      while (acc_q.size() < 8 && budget < 100) begin
         tick();
         budget++;
      end
      chk("midrst_busy_before", bus_if.busy, 1'b1);
      reset      = 1'b0;
      prev_stall = 1'b0;
      #1;
      chk("midrst_tx_valid", bus_if.tx_valid, 1'b0);
      chk("midrst_busy",     bus_if.busy,     1'b0);
      chk("midrst_msg_done", bus_if.msg_done, 1'b0);
      chk("midrst_in_ready", bus_if.in_ready, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      run_vec(vecs[0], 10);
      tick();

      // send_req held high: back-to-back pose messages
      pq.delete();
      for (int m = 0; m < 2; m++)
         for (int i = 0; i < 12; i++) pq.push_back(8'h01 + 8'(i));
      clear_obs();
      toggle_mode      = 1'b0;
      bus_if.send_type = MSG_TYPE_POSE;
      bus_if.send_req  = 1'b1;
      budget = 0;
      while (done_cnt < 1 && budget < 300) begin
         tick();
         budget++;
      end
      first_done = done_cyc;
      n1 = acc_q.size();
      chk("b2b_first_len", n1, HLEN + 12 + CS);
      while (acc_q.size() == n1 && budget < 300) begin
         tick();
         budget++;
      end
      bus_if.send_req = 1'b0;
      if (acc_q.size() > n1 && n1 > 0) begin
         chk("b2b_restart_cycle", acc_cyc[n1], first_done + 1);
         chk("b2b_idle_gap", acc_cyc[n1] - acc_cyc[n1-1], 2);
         chk("b2b_byte0", acc_q[n1], 8'h4B);
      end else begin
         chk("b2b_second_started", acc_q.size() > n1, 1'b1);
      end
      while (done_cnt < 2 && budget < 300) begin
         tick();
         budget++;
      end
      chk("b2b_done_count", done_cnt, 2);
      chk("b2b_total_len", acc_q.size(), 2 * (HLEN + 12 + CS));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
